// File: rtl/store_queue_fwd_pkg.sv
// Shared types and default sizing for the store queue and its forwarding lookup.
package store_queue_fwd_pkg;

    localparam int SQ_DEPTH_DEF     = 8;
    localparam int NUM_LD_PORTS_DEF = 2;
    localparam int SQ_ROB_IDX_W     = 5;

    typedef enum logic [1:0] {
        SQ_FREE  = 2'd0,
        SQ_ALLOC = 2'd1,
        SQ_READY = 2'd2,
        SQ_CMT   = 2'd3
    } sq_state_t;

    typedef struct packed {
        sq_state_t               state;
        logic [SQ_ROB_IDX_W-1:0] rob_idx;
        logic [31:0]             addr;
        logic [31:0]             wdata;
        logic [3:0]              wmask;
    } sq_entry_t;

endpackage

// File: rtl/store_queue_fwd_if.sv
// Dispatch / update / commit / D-cache / load-lookup bundle of the store queue.
interface store_queue_fwd_if
    import store_queue_fwd_pkg::*;
#(
    parameter int SQ_DEPTH     = SQ_DEPTH_DEF,
    parameter int NUM_LD_PORTS = NUM_LD_PORTS_DEF,
    parameter int ROB_IDX_W    = SQ_ROB_IDX_W
);
    localparam int PTR_W = $clog2(SQ_DEPTH) + 1;

    logic                                   flush;
    logic                                   alloc_valid;
    logic [ROB_IDX_W-1:0]                   alloc_rob_idx;
    logic                                   alloc_ready;
    logic [PTR_W-1:0]                       alloc_ptr;
    logic                                   upd_valid;
    logic [PTR_W-1:0]                       upd_ptr;
    logic [31:0]                            upd_addr;
    logic [31:0]                            upd_wdata;
    logic [3:0]                             upd_wmask;
    logic                                   commit_valid;
    logic                                   mem_req_valid;
    logic                                   mem_req_ready;
    logic [31:0]                            mem_req_addr;
    logic [31:0]                            mem_req_wdata;
    logic [3:0]                             mem_req_wmask;
    logic [NUM_LD_PORTS-1:0]                ld_valid;
    logic [NUM_LD_PORTS-1:0][31:0]          ld_addr;
    logic [NUM_LD_PORTS-1:0][3:0]           ld_rmask;
    logic [NUM_LD_PORTS-1:0][PTR_W-1:0]     ld_sq_tail;
    logic [NUM_LD_PORTS-1:0]                fwd_hit;
    logic [NUM_LD_PORTS-1:0][31:0]          fwd_data;
    logic [NUM_LD_PORTS-1:0]                fwd_stall;

    modport master (
        output flush, alloc_valid, alloc_rob_idx, upd_valid, upd_ptr, upd_addr, upd_wdata,
               upd_wmask, commit_valid, mem_req_ready, ld_valid, ld_addr, ld_rmask, ld_sq_tail,
        input  alloc_ready, alloc_ptr, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask,
               fwd_hit, fwd_data, fwd_stall
    );

    modport slave (
        input  flush, alloc_valid, alloc_rob_idx, upd_valid, upd_ptr, upd_addr, upd_wdata,
               upd_wmask, commit_valid, mem_req_ready, ld_valid, ld_addr, ld_rmask, ld_sq_tail,
        output alloc_ready, alloc_ptr, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask,
               fwd_hit, fwd_data, fwd_stall
    );

endinterface

// File: rtl/store_queue_fwd_lookup.sv
// Per-load-port forwarding scan: walks [head, ld_tail) youngest first and stops at the first relevant store.
module sq_fwd_lookup
    import store_queue_fwd_pkg::*;
#(
    parameter int SQ_DEPTH = SQ_DEPTH_DEF,
    parameter int PTR_W    = $clog2(SQ_DEPTH) + 1
) (
    input  sq_state_t [SQ_DEPTH-1:0]        state_i,
    input  logic      [SQ_DEPTH-1:0][31:0]  addr_i,
    input  logic      [SQ_DEPTH-1:0][31:0]  wdata_i,
    input  logic      [SQ_DEPTH-1:0][3:0]   wmask_i,
    input  logic      [PTR_W-1:0]           head_i,
    input  logic                            ld_valid_i,
    input  logic      [31:0]                ld_addr_i,
    input  logic      [3:0]                 ld_rmask_i,
    input  logic      [PTR_W-1:0]           ld_tail_i,
    output logic                            hit_o,
    output logic                            stall_o,
    output logic      [31:0]                data_o
);
    localparam int IDX_W = PTR_W - 1;

    logic             done;
    logic [PTR_W-1:0] span;
    logic [IDX_W-1:0] eidx;

    always_comb begin
        hit_o   = 1'b0;
        stall_o = 1'b0;
        data_o  = '0;
        done    = 1'b0;
        eidx    = '0;
        // Modular distance handles a snapshot whose low bits sit below head.
        span    = ld_tail_i - head_i;
        if (ld_valid_i) begin
            for (int k = 1; k <= SQ_DEPTH; k++) begin
                eidx = ld_tail_i[IDX_W-1:0] - IDX_W'(k);
                if (!done && PTR_W'(k) <= span) begin
                    if (state_i[eidx] == SQ_ALLOC) begin
                        stall_o = 1'b1;
                        done    = 1'b1;
                    end else if (state_i[eidx] != SQ_FREE && addr_i[eidx] == ld_addr_i &&
                                 (ld_rmask_i & wmask_i[eidx]) != 4'h0) begin
                        done = 1'b1;
                        if ((ld_rmask_i & ~wmask_i[eidx]) == 4'h0) begin
                            hit_o  = 1'b1;
                            data_o = wdata_i[eidx];
                        end else begin
                            stall_o = 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_queue_fwd.sv
// Program-ordered store queue: dispatch, address/data update, ROB commit, D-cache drain and load forwarding.
module store_queue_fwd
    import store_queue_fwd_pkg::*;
#(
    parameter int SQ_DEPTH     = SQ_DEPTH_DEF,
    parameter int NUM_LD_PORTS = NUM_LD_PORTS_DEF
) (
    input logic              clk,
    input logic              rst,
    store_queue_fwd_if.slave sq
);
    localparam int IDX_W = $clog2(SQ_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    typedef logic [PTR_W-1:0] ptr_t;

    sq_entry_t ent_q [SQ_DEPTH];
    sq_entry_t ent_d [SQ_DEPTH];
    ptr_t      head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    ptr_t      spec_len;
    logic [IDX_W-1:0] head_idx, cmt_idx, tail_idx, upd_idx, off;
    logic      full, alloc_fire, commit_fire, drain_fire;

    assign head_idx = head_q[IDX_W-1:0];
    assign cmt_idx  = cmt_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign upd_idx  = sq.upd_ptr[IDX_W-1:0];

    assign full        = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
    assign alloc_fire  = sq.alloc_valid && !full && !sq.flush;
    assign commit_fire = sq.commit_valid && (cmt_q != tail_q) && (ent_q[cmt_idx].state == SQ_READY);
    assign drain_fire  = sq.mem_req_valid && sq.mem_req_ready;

    assign sq.alloc_ready   = !full;
    assign sq.alloc_ptr     = tail_q;
    assign sq.mem_req_valid = (ent_q[head_idx].state == SQ_CMT);
    assign sq.mem_req_addr  = ent_q[head_idx].addr;
    assign sq.mem_req_wdata = ent_q[head_idx].wdata;
    assign sq.mem_req_wmask = ent_q[head_idx].wmask;

    always_comb begin
        head_d   = head_q + ptr_t'(drain_fire);
        cmt_d    = cmt_q + ptr_t'(commit_fire);
        // Flush rewinds to the post-commit boundary so a same-cycle commit survives.
        tail_d   = sq.flush ? cmt_d : tail_q + ptr_t'(alloc_fire);
        spec_len = tail_q - cmt_d;
        off      = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            off      = IDX_W'(i) - cmt_d[IDX_W-1:0];
            if (sq.upd_valid && upd_idx == IDX_W'(i) && ent_q[i].state == SQ_ALLOC) begin
                ent_d[i].state = SQ_READY;
                ent_d[i].addr  = sq.upd_addr;
                ent_d[i].wdata = sq.upd_wdata;
                ent_d[i].wmask = sq.upd_wmask;
            end
            if (commit_fire && cmt_idx == IDX_W'(i))
                ent_d[i].state = SQ_CMT;
            if (drain_fire && head_idx == IDX_W'(i))
                ent_d[i].state = SQ_FREE;
            if (alloc_fire && tail_idx == IDX_W'(i)) begin
                ent_d[i].state   = SQ_ALLOC;
                ent_d[i].rob_idx = sq.alloc_rob_idx;
            end
            if (sq.flush && ptr_t'(off) < spec_len)
                ent_d[i].state = SQ_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
            for (int i = 0; i < SQ_DEPTH; i++)
                ent_q[i] <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
            ent_q  <= ent_d;
        end
    end

    always @(posedge clk) begin
        if (!rst && sq.upd_valid)
            assert (ent_q[upd_idx].state == SQ_ALLOC);
        if (!rst && sq.commit_valid)
            assert (cmt_q != tail_q && ent_q[cmt_idx].state == SQ_READY);
    end

    sq_state_t [SQ_DEPTH-1:0]       st;
    logic      [SQ_DEPTH-1:0][31:0] ad, wd;
    logic      [SQ_DEPTH-1:0][3:0]  wm;
    logic [SQ_ROB_IDX_W-1:0]        unused_rob;
    logic                           unused_ok;

    always_comb begin
        unused_rob = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            st[i] = ent_q[i].state;
            ad[i] = ent_q[i].addr;
            wd[i] = ent_q[i].wdata;
            wm[i] = ent_q[i].wmask;
            unused_rob = unused_rob ^ ent_q[i].rob_idx;
        end
    end
    assign unused_ok = ^{unused_rob, sq.upd_ptr[IDX_W]};

    logic [NUM_LD_PORTS-1:0]       hit, stall;
    logic [NUM_LD_PORTS-1:0][31:0] fdata;

    for (genvar p = 0; p < NUM_LD_PORTS; p++) begin : g_lkp
        sq_fwd_lookup #(.SQ_DEPTH(SQ_DEPTH), .PTR_W(PTR_W)) u_lkp (
            .state_i    (st),
            .addr_i     (ad),
            .wdata_i    (wd),
            .wmask_i    (wm),
            .head_i     (head_q),
            .ld_valid_i (sq.ld_valid[p]),
            .ld_addr_i  (sq.ld_addr[p]),
            .ld_rmask_i (sq.ld_rmask[p]),
            .ld_tail_i  (sq.ld_sq_tail[p]),
            .hit_o      (hit[p]),
            .stall_o    (stall[p]),
            .data_o     (fdata[p])
        );
    end

    assign sq.fwd_hit   = hit;
    assign sq.fwd_stall = stall;
    assign sq.fwd_data  = fdata;

endmodule

// File: tb/tb_store_queue_fwd.sv
// Directed bench for store_queue_fwd; drains are checked against a commit-ordered scoreboard.
module tb_store_queue_fwd;
    logic clk;
    logic rst;

    store_queue_fwd_if #(.SQ_DEPTH(8), .NUM_LD_PORTS(2)) sq_if ();

    store_queue_fwd #(.SQ_DEPTH(8), .NUM_LD_PORTS(2)) dut (
        .clk (clk),
        .rst (rst),
        .sq  (sq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int ndrain = 0;
    logic [67:0] sb[$];
    logic [67:0] exp_d;
    logic [31:0] m_addr [8];
    logic [31:0] m_data [8];
    logic [3:0]  m_mask [8];
    logic [3:0]  tl, cm;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        sb.delete();
        tl = '0;
        cm = '0;
    endtask

    task automatic do_alloc();
        sq_if.alloc_valid   = 1'b1;
        sq_if.alloc_rob_idx = 5'(tl);
        cyc();
        sq_if.alloc_valid = 1'b0;
        tl++;
    endtask

    task automatic do_upd(input logic [3:0] p, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m);
        sq_if.upd_valid = 1'b1;
        sq_if.upd_ptr   = p;
        sq_if.upd_addr  = a;
        sq_if.upd_wdata = d;
        sq_if.upd_wmask = m;
        m_addr[p[2:0]]  = a;
        m_data[p[2:0]]  = d;
        m_mask[p[2:0]]  = m;
        cyc();
        sq_if.upd_valid = 1'b0;
    endtask

    task automatic do_commit();
        sb.push_back({m_addr[cm[2:0]], m_data[cm[2:0]], m_mask[cm[2:0]]});
        sq_if.commit_valid = 1'b1;
        cyc();
        sq_if.commit_valid = 1'b0;
        cm++;
    endtask

    task automatic lookup(input int p, input logic [31:0] a, input logic [3:0] m, input logic [3:0] t);
        sq_if.ld_valid[p]   = 1'b1;
        sq_if.ld_addr[p]    = a;
        sq_if.ld_rmask[p]   = m;
        sq_if.ld_sq_tail[p] = t;
    endtask

    // D-cache side: every accepted write must match the oldest committed store.
    always @(negedge clk) begin
        if (!rst && sq_if.mem_req_valid && sq_if.mem_req_ready) begin
            nvec++;
            assert (sb.size() != 0) else begin
                nerr++;
                $error("FAIL drain_spurious: got addr %0h expected no request", sq_if.mem_req_addr);
            end
            if (sb.size() != 0) begin
                exp_d = sb.pop_front();
                chk("drain", {sq_if.mem_req_addr, sq_if.mem_req_wdata, sq_if.mem_req_wmask}, exp_d);
            end
            ndrain++;
        end
    end

    initial begin
        rst = 1'b1;
        sq_if.flush = 0; sq_if.alloc_valid = 0; sq_if.alloc_rob_idx = 0;
        sq_if.upd_valid = 0; sq_if.upd_ptr = 0; sq_if.upd_addr = 0; sq_if.upd_wdata = 0;
        sq_if.upd_wmask = 0; sq_if.commit_valid = 0; sq_if.mem_req_ready = 0;
        sq_if.ld_valid = 0; sq_if.ld_addr = 0; sq_if.ld_rmask = 0; sq_if.ld_sq_tail = 0;

        // Reset state
        do_reset();
        #1;
        chk("rst_alloc_ready", sq_if.alloc_ready, 1);
        chk("rst_alloc_ptr", sq_if.alloc_ptr, 0);
        chk("rst_mem_valid", sq_if.mem_req_valid, 0);
        chk("rst_fwd_hit", sq_if.fwd_hit, 0);
        chk("rst_fwd_stall", sq_if.fwd_stall, 0);
        chk("rst_fwd_data", sq_if.fwd_data, 0);

        // Fill to full, then an ignored 9th alloc
        for (int i = 0; i < 8; i++) do_alloc();
        chk("full_ready", sq_if.alloc_ready, 0);
        chk("full_ptr", sq_if.alloc_ptr, 4'h8);
        sq_if.alloc_valid = 1'b1;
        cyc();
        sq_if.alloc_valid = 1'b0;
        chk("full_ptr_9th", sq_if.alloc_ptr, 4'h8);
        chk("full_ready_9th", sq_if.alloc_ready, 0);

        // Full forward; port1 disabled with live-looking inputs
        do_reset();
        do_alloc();
        chk("alloc_ptr_1", sq_if.alloc_ptr, 1);
        do_upd(4'd0, 32'h100, 32'hDEADBEEF, 4'hF);
        lookup(0, 32'h100, 4'h3, 4'd1);
        lookup(1, 32'h100, 4'hF, 4'd1);
        sq_if.ld_valid[1] = 1'b0;
        #1;
        chk("fwd_hit", sq_if.fwd_hit[0], 1);
        chk("fwd_data", sq_if.fwd_data[0], 32'hDEADBEEF);
        chk("fwd_nostall", sq_if.fwd_stall[0], 0);
        chk("p1_off", {sq_if.fwd_hit[1], sq_if.fwd_stall[1], sq_if.fwd_data[1]}, 0);
        lookup(0, 32'h100, 4'h3, 4'd0);
        #1;
        chk("empty_range", {sq_if.fwd_hit[0], sq_if.fwd_stall[0]}, 0);
        cyc();

        // Partial overlap, no overlap, unresolved older store
        do_alloc();
        do_upd(4'd1, 32'h200, 32'h000000AA, 4'h1);
        lookup(0, 32'h200, 4'h3, 4'd2);
        #1;
        chk("partial_stall", {sq_if.fwd_hit[0], sq_if.fwd_stall[0]}, 2'b01);
        lookup(0, 32'h200, 4'hC, 4'd2);
        #1;
        chk("no_overlap", {sq_if.fwd_hit[0], sq_if.fwd_stall[0]}, 2'b00);
        cyc();
        do_alloc();
        lookup(0, 32'h300, 4'hF, 4'd3);
        #1;
        chk("alloc_stall", {sq_if.fwd_hit[0], sq_if.fwd_stall[0]}, 2'b01);
        cyc();
        do_upd(4'd2, 32'h300, 32'h33333333, 4'hF);
        #1;
        chk("alloc_then_hit", {sq_if.fwd_hit[0], sq_if.fwd_stall[0]}, 2'b10);
        chk("alloc_then_data", sq_if.fwd_data[0], 32'h33333333);
        cyc();

        // Youngest older store wins, per-port snapshot
        do_alloc();
        do_upd(4'd3, 32'h40, 32'h11111111, 4'hF);
        do_alloc();
        do_upd(4'd4, 32'h40, 32'h22222222, 4'hF);
        lookup(0, 32'h40, 4'hF, 4'd5);
        lookup(1, 32'h40, 4'hF, 4'd4);
        #1;
        chk("young_p0", {sq_if.fwd_hit[0], sq_if.fwd_data[0]}, {1'b1, 32'h22222222});
        chk("young_p1", {sq_if.fwd_hit[1], sq_if.fwd_data[1]}, {1'b1, 32'h11111111});
        cyc();
        sq_if.ld_valid = 0;

        // Flush: 2 committed + 3 speculative, same-cycle alloc dropped
        do_reset();
        for (int i = 0; i < 5; i++) begin
            chk("flush_alloc_ptr", sq_if.alloc_ptr, 4'(i));
            do_alloc();
            do_upd(4'(i), 32'h1000 + 32'(4 * i), 32'h50000000 + 32'(i), 4'hF);
        end
        do_commit();
        do_commit();
        sq_if.flush = 1'b1;
        sq_if.alloc_valid = 1'b1;
        cyc();
        sq_if.flush = 1'b0;
        sq_if.alloc_valid = 1'b0;
        tl = cm;
        chk("flush_tail", sq_if.alloc_ptr, 4'd2);
        lookup(0, 32'h100C, 4'hF, 4'd5);
        lookup(1, 32'h1004, 4'hF, 4'd5);
        #1;
        chk("flush_freed", {sq_if.fwd_hit[0], sq_if.fwd_stall[0]}, 2'b00);
        chk("flush_kept", {sq_if.fwd_hit[1], sq_if.fwd_data[1]}, {1'b1, 32'h50000001});
        chk("flush_mem_valid", sq_if.mem_req_valid, 1);
        cyc();
        sq_if.ld_valid = 0;
        ndrain = 0;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            sq_if.mem_req_ready = ~sq_if.mem_req_ready;
            cyc();
        end
        sq_if.mem_req_ready = 1'b0;
        chk("flush_sb_empty", sb.size(), 0);
        chk("flush_drains", ndrain, 2);
        #1;
        chk("flush_empty_valid", sq_if.mem_req_valid, 0);
        chk("flush_empty_ptr", sq_if.alloc_ptr, 4'd2);

        // Wrap: 20 alloc/upd/commit/drain rounds
        do_reset();
        sq_if.mem_req_ready = 1'b1;
        for (int it = 0; it < 20; it++) begin
            chk("wrap_alloc_ptr", sq_if.alloc_ptr, tl);
            do_alloc();
            do_upd(tl - 4'd1, 32'h2000 + 32'(4 * (it % 3)), 32'(it) * 32'h01010101 + 32'h0F000000, 4'hF);
            do_commit();
        end
        for (int i = 0; i < 10 && sb.size() != 0; i++) cyc();
        chk("wrap_sb_empty", sb.size(), 0);
        sq_if.mem_req_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            do_alloc();
            do_upd(tl - 4'd1, 32'h3000 + 32'(4 * k), 32'hA0000000 + 32'(k), 4'hF);
        end
        chk("wrap_tail", sq_if.alloc_ptr, 4'd10);
        lookup(0, 32'h3010, 4'hF, 4'd10);
        lookup(1, 32'h3000, 4'hF, 4'd10);
        #1;
        chk("wrap_hit_new", {sq_if.fwd_hit[0], sq_if.fwd_data[0]}, {1'b1, 32'hA0000004});
        chk("wrap_hit_old", {sq_if.fwd_hit[1], sq_if.fwd_data[1]}, {1'b1, 32'hA0000000});
        lookup(0, 32'h2000, 4'hF, 4'd10);
        lookup(1, 32'h2004, 4'hF, 4'd10);
        #1;
        chk("wrap_no_stale", {sq_if.fwd_hit, sq_if.fwd_stall}, 0);
        cyc();
        sq_if.ld_valid = 0;

        // Reset while a committed store waits on the D-cache
        do_commit();
        #1;
        chk("pend_valid", sq_if.mem_req_valid, 1);
        chk("pend_addr", sq_if.mem_req_addr, 32'h3000);
        cyc();
        chk("pend_hold", sq_if.mem_req_valid, 1);
        rst = 1'b1;
        cyc();
        chk("rst_drop_valid", sq_if.mem_req_valid, 0);
        chk("rst_drop_ptr", sq_if.alloc_ptr, 0);
        rst = 1'b0;
        sb.delete();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
